// File: rtl/layer_sequencer_if.sv
// Host/config and MAC-array control bundle of the layer sequencer.
// The host side (master) drives start/config; the sequencer (slave) drives status and lane strobes.
interface layer_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int LAYER_W   = 3,
  parameter int CNT_W     = 11,
  parameter int ADDR_W    = 10
);
  logic                 start;
  logic                 cfg_we;
  logic [LAYER_W-1:0]   cfg_idx;
  logic [CNT_W-1:0]     cfg_fan_in;
  logic [CNT_W-1:0]     cfg_neurons;
  logic [LAYER_W-1:0]   cfg_num_layers;
  logic                 busy;
  logic                 done;
  logic [NUM_LANES-1:0] rd_en;
  logic [NUM_LANES-1:0] mac_en;
  logic                 mac_clr;
  logic [NUM_LANES-1:0] act_fn_en;
  logic                 feed_through;
  logic [ADDR_W-1:0]    base_addr;
  logic [LAYER_W-1:0]   layer_no;
  logic [CNT_W-1:0]     pass_no;

  modport master (
    output start, cfg_we, cfg_idx, cfg_fan_in, cfg_neurons, cfg_num_layers,
    input  busy, done, rd_en, mac_en, mac_clr, act_fn_en, feed_through,
           base_addr, layer_no, pass_no
  );

  modport slave (
    input  start, cfg_we, cfg_idx, cfg_fan_in, cfg_neurons, cfg_num_layers,
    output busy, done, rd_en, mac_en, mac_clr, act_fn_en, feed_through,
           base_addr, layer_no, pass_no
  );
endinterface

// File: rtl/layer_sequencer.sv
// Walks a configured stack of FC layers, splitting each into NUM_LANES-wide passes and
// driving weight reads, delayed MAC enables, accumulator clears and activation strobes.
module layer_sequencer #(
  parameter int NUM_LANES  = 4,
  parameter int MAX_LAYERS = 4,
  parameter int LAYER_W    = 3,
  parameter int CNT_W      = 11,
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 4
) (
  input logic             clk,
  input logic             rst_n,
  layer_sequencer_if.slave bus
);

  localparam int IDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_COMPUTE  = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_ACTIVATE = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;

  localparam logic [LAYER_W-1:0] MAX_L   = LAYER_W'(MAX_LAYERS);
  localparam logic [CNT_W:0]     LANES_W = (CNT_W+1)'(NUM_LANES);
  localparam logic [CNT_W:0]     LAT_W   = (CNT_W+1)'(MEM_LAT);
  localparam logic [CNT_W:0]     ONE_W   = (CNT_W+1)'(1);

  logic [CNT_W-1:0]     fan_in_r  [MAX_LAYERS];
  logic [CNT_W-1:0]     neurons_r [MAX_LAYERS];
  logic [NUM_LANES-1:0] pipe_r    [MEM_LAT];

  logic [2:0]           state_r;
  logic [LAYER_W-1:0]   nl_r;
  logic [LAYER_W-1:0]   layer_r;
  logic [CNT_W-1:0]     pass_r;
  logic [ADDR_W-1:0]    base_r;
  logic [CNT_W:0]       cnt_r;
  logic [NUM_LANES-1:0] mask_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 mac_clr_r;
  logic                 feed_r;
  logic [NUM_LANES-1:0] rd_en_r;
  logic [NUM_LANES-1:0] act_r;

  logic [IDX_W-1:0]     idx_s;
  logic [CNT_W-1:0]     neur_eff_s;
  logic [CNT_W:0]       len_s;
  logic [CNT_W:0]       pass_base_s;
  logic [CNT_W:0]       next_base_s;
  logic [CNT_W:0]       rem_s;
  logic [NUM_LANES-1:0] mask_s;
  logic                 more_pass_s;
  logic                 more_layer_s;
  logic [LAYER_W-1:0]   nl_clamp_s;

  // Per-pass geometry of the current layer; all pass arithmetic is one bit wider than CNT_W.
  always_comb begin
    idx_s       = layer_r[IDX_W-1:0];
    if (neurons_r[idx_s] == '0) begin
      neur_eff_s = CNT_W'(1);
    end else begin
      neur_eff_s = neurons_r[idx_s];
    end
    len_s       = {1'b0, fan_in_r[idx_s]} + ONE_W;
    pass_base_s = {1'b0, pass_r} * LANES_W;
    next_base_s = pass_base_s + LANES_W;
    rem_s       = {1'b0, neur_eff_s} - pass_base_s;
    mask_s      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mask_s[i] = (rem_s > (CNT_W+1)'(i));
    end
    more_pass_s  = (next_base_s < {1'b0, neur_eff_s});
    more_layer_s = ((layer_r + LAYER_W'(1)) < nl_r);
    if (bus.cfg_num_layers > MAX_L) begin
      nl_clamp_s = MAX_L;
    end else begin
      nl_clamp_s = bus.cfg_num_layers;
    end
  end

  // Layer config register file, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        fan_in_r[i]  <= '0;
        neurons_r[i] <= '0;
      end
    end else if (bus.cfg_we && !busy_r && (bus.cfg_idx < MAX_L)) begin
      fan_in_r[bus.cfg_idx[IDX_W-1:0]]  <= bus.cfg_fan_in;
      neurons_r[bus.cfg_idx[IDX_W-1:0]] <= bus.cfg_neurons;
    end
  end

  // rd_en -> mac_en delay line matching the weight memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= rd_en_r;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Sequencer FSM; strobes are registered on the edge that enters their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      nl_r      <= '0;
      layer_r   <= '0;
      pass_r    <= '0;
      base_r    <= '0;
      cnt_r     <= '0;
      mask_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      mac_clr_r <= 1'b0;
      feed_r    <= 1'b0;
      rd_en_r   <= '0;
      act_r     <= '0;
    end else begin
      done_r    <= 1'b0;
      mac_clr_r <= 1'b0;
      feed_r    <= 1'b0;
      act_r     <= '0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            if (nl_clamp_s == '0) begin
              done_r <= 1'b1;
            end else begin
              nl_r      <= nl_clamp_s;
              layer_r   <= '0;
              pass_r    <= '0;
              base_r    <= '0;
              busy_r    <= 1'b1;
              mac_clr_r <= 1'b1;
              state_r   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          rd_en_r <= mask_s;
          mask_r  <= mask_s;
          cnt_r   <= len_s;
          state_r <= S_COMPUTE;
        end
        S_COMPUTE: begin
          base_r <= base_r + ADDR_W'(1);
          if (cnt_r == ONE_W) begin
            rd_en_r <= '0;
            cnt_r   <= LAT_W;
            state_r <= S_DRAIN;
          end else begin
            cnt_r <= cnt_r - ONE_W;
          end
        end
        S_DRAIN: begin
          if (cnt_r == ONE_W) begin
            act_r   <= mask_r;
            state_r <= S_ACTIVATE;
          end else begin
            cnt_r <= cnt_r - ONE_W;
          end
        end
        S_ACTIVATE: begin
          state_r <= S_NEXT;
        end
        S_NEXT: begin
          if (more_pass_s) begin
            pass_r    <= pass_r + CNT_W'(1);
            mac_clr_r <= 1'b1;
            state_r   <= S_LOAD;
          end else if (more_layer_s) begin
            layer_r   <= layer_r + LAYER_W'(1);
            pass_r    <= '0;
            mac_clr_r <= 1'b1;
            feed_r    <= 1'b1;
            state_r   <= S_LOAD;
          end else begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: begin
          rd_en_r <= '0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.rd_en        = rd_en_r;
  assign bus.mac_en       = pipe_r[MEM_LAT-1];
  assign bus.mac_clr      = mac_clr_r;
  assign bus.act_fn_en    = act_r;
  assign bus.feed_through = feed_r;
  assign bus.base_addr    = base_r;
  assign bus.layer_no     = layer_r;
  assign bus.pass_no      = pass_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer: cycle-exact single pass, multi-pass,
// multi-layer, clamping, busy protection, mid-run reset and address wrap.
module tb_layer_sequencer;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  layer_sequencer_if #(.NUM_LANES(4), .LAYER_W(3), .CNT_W(11), .ADDR_W(10)) bus ();
  layer_sequencer_if #(.NUM_LANES(4), .LAYER_W(3), .CNT_W(11), .ADDR_W(4))  bus2 ();

  layer_sequencer #(.NUM_LANES(4), .MAX_LAYERS(4), .LAYER_W(3), .CNT_W(11),
                    .ADDR_W(10), .MEM_LAT(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  layer_sequencer #(.NUM_LANES(4), .MAX_LAYERS(4), .LAYER_W(3), .CNT_W(11),
                    .ADDR_W(4), .MEM_LAT(4)) u_dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         mon_done_cyc, mon_dones, mon_clr, mon_feed, mon_rd, mon_mac;
  logic [3:0] mon_masks[$];
  logic [10:0] mon_passes[$];
  logic [2:0] mon_feed_layers[$];

  task automatic cfg_write(input logic [2:0] idx, input logic [10:0] fan, input logic [10:0] neur);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_fan_in = fan; bus.cfg_neurons = neur;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Raises start so that the next posedge is edge 0 of the run.
  task automatic begin_run(input logic [2:0] nl);
    @(negedge clk);
    bus.cfg_num_layers = nl;
    bus.start = 1'b1;
  endtask

  // Steps cycles 1..budget after edge 0, recording activity; stops 4 cycles after the first done.
  task automatic monitor(input int budget, input int poke);
    int tail;
    logic [3:0] prev_rd;
    mon_done_cyc = -1; mon_dones = 0; mon_clr = 0; mon_feed = 0; mon_rd = 0; mon_mac = 0;
    mon_masks.delete(); mon_passes.delete(); mon_feed_layers.delete();
    prev_rd = 4'd0;
    tail = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.cfg_we = 1'b0;
      if (c == poke) begin
        bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0;
        bus.cfg_fan_in = 11'd0; bus.cfg_neurons = 11'd8;
      end
      if (bus.mac_clr) mon_clr++;
      if (bus.feed_through) begin
        mon_feed++;
        mon_feed_layers.push_back(bus.layer_no);
      end
      if (bus.rd_en != 4'd0) begin
        mon_rd++;
        if (prev_rd == 4'd0) begin
          mon_masks.push_back(bus.rd_en);
          mon_passes.push_back(bus.pass_no);
        end
      end
      if (bus.mac_en != 4'd0) mon_mac++;
      prev_rd = bus.rd_en;
      if (bus.done) begin
        mon_dones++;
        if (mon_done_cyc < 0) begin
          mon_done_cyc = c;
          tail = c + 4;
        end
      end
      if (c == tail) break;
    end
  endtask

  task automatic test_reset;
    logic [38:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus.busy, bus.done, bus.mac_clr, bus.feed_through, bus.rd_en, bus.mac_en,
           bus.act_fn_en, bus.base_addr, bus.layer_no, bus.pass_no};
    tests_run++;
    if (got !== 39'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h expected=0", got);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.busy, bus.done, bus.mac_clr, bus.feed_through, bus.rd_en, bus.mac_en,
           bus.act_fn_en, bus.base_addr, bus.layer_no, bus.pass_no};
    tests_run++;
    if (got !== 39'd0) begin
      tests_failed++;
      $display("FAIL reset_idle got=%h expected=0", got);
    end
  endtask

  task automatic test_single_layer;
    logic [15:0] got, exp;
    cfg_write(3'd0, 11'd3, 11'd4);
    begin_run(3'd1);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      exp = {(c >= 1 && c <= 11), (c == 12), (c == 1), 1'b0,
             (c >= 2 && c <= 5) ? 4'hF : 4'h0,
             (c >= 6 && c <= 9) ? 4'hF : 4'h0,
             (c == 10) ? 4'hF : 4'h0};
      got = {bus.busy, bus.done, bus.mac_clr, bus.feed_through, bus.rd_en, bus.mac_en, bus.act_fn_en};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL single_cycle%0d got=%h expected=%h", c, got, exp);
      end
    end
    tests_run++;
    if (bus.base_addr !== 10'd4) begin
      tests_failed++;
      $display("FAIL single_base got=%0d expected=4", bus.base_addr);
    end
  endtask

  task automatic test_multi_pass;
    cfg_write(3'd0, 11'd1, 11'd10);
    begin_run(3'd1);
    monitor(60, 0);
    tests_run++;
    if (mon_masks.size() !== 3 || mon_masks[0] !== 4'hF || mon_masks[1] !== 4'hF || mon_masks[2] !== 4'h3) begin
      tests_failed++;
      $display("FAIL multi_masks got n=%0d %h %h %h expected n=3 f f 3",
               mon_masks.size(), mon_masks[0], mon_masks[1], mon_masks[2]);
    end
    tests_run++;
    if (mon_passes[0] !== 11'd0 || mon_passes[1] !== 11'd1 || mon_passes[2] !== 11'd2) begin
      tests_failed++;
      $display("FAIL multi_pass_no got %0d %0d %0d expected 0 1 2", mon_passes[0], mon_passes[1], mon_passes[2]);
    end
    tests_run++;
    if (mon_clr !== 3 || mon_feed !== 0 || mon_rd !== 6 || mon_mac !== 6) begin
      tests_failed++;
      $display("FAIL multi_counts got clr=%0d feed=%0d rd=%0d mac=%0d expected 3 0 6 6", mon_clr, mon_feed, mon_rd, mon_mac);
    end
    tests_run++;
    if (mon_done_cyc !== 28 || bus.base_addr !== 10'd6) begin
      tests_failed++;
      $display("FAIL multi_done got cyc=%0d base=%0d expected 28 6", mon_done_cyc, bus.base_addr);
    end
  endtask

  task automatic test_three_layers;
    cfg_write(3'd0, 11'd784, 11'd28);
    cfg_write(3'd1, 11'd27, 11'd28);
    cfg_write(3'd2, 11'd27, 11'd10);
    begin_run(3'd3);
    monitor(7000, 0);
    tests_run++;
    if (mon_clr !== 17 || mon_masks.size() !== 17 || mon_masks[16] !== 4'h3) begin
      tests_failed++;
      $display("FAIL layers_passes got clr=%0d n=%0d last=%h expected 17 17 3", mon_clr, mon_masks.size(), mon_masks[16]);
    end
    tests_run++;
    if (mon_feed !== 2 || mon_feed_layers[0] !== 3'd1 || mon_feed_layers[1] !== 3'd2) begin
      tests_failed++;
      $display("FAIL layers_feed got n=%0d l=%0d,%0d expected 2 1,2", mon_feed, mon_feed_layers[0], mon_feed_layers[1]);
    end
    tests_run++;
    if (mon_dones !== 1 || mon_done_cyc !== 5895) begin
      tests_failed++;
      $display("FAIL layers_done got n=%0d cyc=%0d expected 1 5895", mon_dones, mon_done_cyc);
    end
    tests_run++;
    if (bus.base_addr !== 10'd655 || bus.layer_no !== 3'd2) begin
      tests_failed++;
      $display("FAIL layers_end got base=%0d layer=%0d expected 655 2", bus.base_addr, bus.layer_no);
    end
  endtask

  task automatic test_layer_count;
    begin_run(3'd0);
    monitor(10, 0);
    tests_run++;
    if (mon_done_cyc !== 1 || mon_dones !== 1 || mon_rd !== 0 || mon_mac !== 0) begin
      tests_failed++;
      $display("FAIL zero_layers got cyc=%0d n=%0d rd=%0d mac=%0d expected 1 1 0 0", mon_done_cyc, mon_dones, mon_rd, mon_mac);
    end
    cfg_write(3'd0, 11'd0, 11'd1);
    cfg_write(3'd1, 11'd0, 11'd1);
    cfg_write(3'd2, 11'd0, 11'd1);
    cfg_write(3'd3, 11'd0, 11'd0);
    cfg_write(3'd5, 11'd9, 11'd9);
    begin_run(3'd7);
    monitor(60, 0);
    tests_run++;
    if (mon_done_cyc !== 33 || mon_clr !== 4 || mon_feed !== 3 || mon_rd !== 4) begin
      tests_failed++;
      $display("FAIL clamp_layers got cyc=%0d clr=%0d feed=%0d rd=%0d expected 33 4 3 4", mon_done_cyc, mon_clr, mon_feed, mon_rd);
    end
    tests_run++;
    if (mon_masks[3] !== 4'h1 || bus.layer_no !== 3'd3) begin
      tests_failed++;
      $display("FAIL clamp_zero_neurons got mask=%h layer=%0d expected 1 3", mon_masks[3], bus.layer_no);
    end
  endtask

  task automatic test_busy_ignore;
    cfg_write(3'd0, 11'd3, 11'd4);
    begin_run(3'd1);
    monitor(30, 3);
    tests_run++;
    if (mon_done_cyc !== 12 || mon_clr !== 1 || mon_rd !== 4 || bus.base_addr !== 10'd4) begin
      tests_failed++;
      $display("FAIL busy_run got cyc=%0d clr=%0d rd=%0d base=%0d expected 12 1 4 4", mon_done_cyc, mon_clr, mon_rd, bus.base_addr);
    end
    begin_run(3'd1);
    monitor(30, 0);
    tests_run++;
    if (mon_done_cyc !== 12 || mon_masks[0] !== 4'hF || mon_rd !== 4) begin
      tests_failed++;
      $display("FAIL busy_cfg_kept got cyc=%0d mask=%h rd=%0d expected 12 f 4", mon_done_cyc, mon_masks[0], mon_rd);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [38:0] got;
    cfg_write(3'd0, 11'd30, 11'd4);
    begin_run(3'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    got = {bus.busy, bus.done, bus.mac_clr, bus.feed_through, bus.rd_en, bus.mac_en,
           bus.act_fn_en, bus.base_addr, bus.layer_no, bus.pass_no};
    tests_run++;
    if (got !== 39'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs got=%h expected=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    monitor(12, 0);
    tests_run++;
    if (mon_dones !== 0 || mon_rd !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done got done=%0d rd=%0d expected 0 0", mon_dones, mon_rd);
    end
    begin_run(3'd1);
    monitor(20, 0);
    tests_run++;
    if (mon_done_cyc !== 9 || mon_masks[0] !== 4'h1 || mon_rd !== 1 || bus.base_addr !== 10'd1) begin
      tests_failed++;
      $display("FAIL abort_rerun got cyc=%0d mask=%h rd=%0d base=%0d expected 9 1 1 1",
               mon_done_cyc, mon_masks[0], mon_rd, bus.base_addr);
    end
  endtask

  task automatic test_addr_wrap;
    int done_cyc;
    @(negedge clk);
    bus2.cfg_we = 1'b1; bus2.cfg_idx = 3'd0; bus2.cfg_fan_in = 11'd19; bus2.cfg_neurons = 11'd1;
    @(negedge clk);
    bus2.cfg_we = 1'b0; bus2.cfg_num_layers = 3'd1; bus2.start = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      if (bus2.done && done_cyc < 0) done_cyc = c;
      if (c == 17) begin
        tests_run++;
        if (bus2.base_addr !== 4'd15) begin
          tests_failed++;
          $display("FAIL wrap_top got=%0d expected=15", bus2.base_addr);
        end
      end
      if (c == 18) begin
        tests_run++;
        if (bus2.base_addr !== 4'd0) begin
          tests_failed++;
          $display("FAIL wrap_zero got=%0d expected=0", bus2.base_addr);
        end
      end
    end
    tests_run++;
    if (done_cyc !== 28 || bus2.base_addr !== 4'd4) begin
      tests_failed++;
      $display("FAIL wrap_end got cyc=%0d base=%0d expected 28 4", done_cyc, bus2.base_addr);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = 3'd0;
    bus.cfg_fan_in = 11'd0; bus.cfg_neurons = 11'd0; bus.cfg_num_layers = 3'd0;
    bus2.start = 1'b0; bus2.cfg_we = 1'b0; bus2.cfg_idx = 3'd0;
    bus2.cfg_fan_in = 11'd0; bus2.cfg_neurons = 11'd0; bus2.cfg_num_layers = 3'd0;
    test_reset();
    test_single_layer();
    test_multi_pass();
    test_three_layers();
    test_layer_count();
    test_busy_ignore();
    test_reset_mid_run();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
